video_stream_gen: RTL and testbench

VIDEO_STREAM_GEN -- requirements
Module: video_stream_gen

---
 rtl/video_stream_gen_if.sv | 26 ++
 rtl/video_stream_gen.sv | 188 ++++++++++++++++++
 tb/tb_video_stream_gen.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/video_stream_gen_if.sv
// Pixel bus between the stream generator and its sink / external pixel source.
interface video_stream_gen_if #(
  parameter int DATA_W = 8,
  parameter int ROW_W  = 9,
  parameter int COL_W  = 10
);
  logic                   pix_req;
  logic [DATA_W-1:0]      pix_in;
  logic                   video_frame_valid;
  logic                   video_line_valid;
  logic                   video_data_valid;
  logic [DATA_W-1:0]      video_data_out;
  logic [ROW_W+COL_W:0]   video_address;

  modport master (
    output pix_req, video_frame_valid, video_line_valid, video_data_valid,
           video_data_out, video_address,
    input  pix_in
  );

  modport slave (
    input  pix_req, video_frame_valid, video_line_valid, video_data_valid,
           video_data_out, video_address,
    output pix_in
  );
endinterface

// File: rtl/video_stream_gen.sv
// Raster video timing generator: fields of lines of pixels with a selectable
// test pattern or an externally fetched pixel stream.
module video_stream_gen #(
  parameter int H_ACTIVE  = 702,
  parameter int V_LINES   = 288,
  parameter int FIELDS    = 2,
  parameter int DATA_W    = 8,
  parameter int PIX_DIV   = 8,
  parameter int PIX_PHASE = 2,
  parameter int H_PRE     = 1500,
  parameter int H_POST    = 1884,
  parameter int V_GAP     = 100000,
  parameter int ROW_W     = 9,
  parameter int COL_W     = 10,
  parameter int NF_W      = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stop,
  input  logic [NF_W-1:0]   nframes,
  input  logic [1:0]        mode,
  video_stream_gen_if.master vid,
  output logic              busy,
  output logic              done
);

  localparam int T_ACT  = H_ACTIVE * PIX_DIV;
  localparam int TMAX_A = (H_PRE > H_POST) ? H_PRE : H_POST;
  localparam int TMAX_B = (V_GAP > T_ACT) ? V_GAP : T_ACT;
  localparam int TMAX   = (TMAX_A > TMAX_B) ? TMAX_A : TMAX_B;
  localparam int TW     = $clog2(TMAX + 1);
  localparam int PW     = $clog2(PIX_DIV);
  localparam int FW     = (FIELDS > 1) ? $clog2(FIELDS) : 1;

  localparam logic [TW-1:0]    T_PRE_END  = TW'(H_PRE - 1);
  localparam logic [TW-1:0]    T_ACT_END  = TW'(T_ACT - 1);
  localparam logic [TW-1:0]    T_POST_END = TW'(H_POST - 1);
  localparam logic [TW-1:0]    T_GAP_END  = TW'(V_GAP - 1);
  localparam logic [PW-1:0]    PH_LAST    = PW'(PIX_DIV - 1);
  localparam logic [PW-1:0]    PH_VALID   = PW'(PIX_PHASE);
  localparam logic [PW-1:0]    PH_ONE     = PW'(1);
  localparam logic [ROW_W-1:0] ROW_LAST   = ROW_W'(V_LINES - 1);
  localparam logic [FW-1:0]    FLD_LAST   = FW'(FIELDS - 1);

  typedef enum logic [2:0] {S_IDLE, S_H_PRE, S_H_ACT, S_H_POST, S_V_GAP} state_t;
  typedef struct packed {
    logic [NF_W-1:0] nframes;
    logic [1:0]      mode;
  } cfg_t;

  state_t           state, state_nx;
  cfg_t             cfg, cfg_nx;
  logic [TW-1:0]    tmr, tmr_nx;
  logic [PW-1:0]    phase, phase_nx;
  logic [COL_W-1:0] col, col_nx;
  logic [ROW_W-1:0] row, row_nx;
  logic [FW-1:0]    field, field_nx;
  logic [NF_W-1:0]  frame, frame_nx;
  logic             done_nx, stop_pend, fbit_nx, pix_edge;

  function automatic logic [DATA_W-1:0] pattern(input logic [1:0] m,
                                                input logic [COL_W-1:0] c,
                                                input logic [ROW_W-1:0] r);
    case (m)
      2'b01:   return DATA_W'(c);
      2'b10:   return DATA_W'(r);
      2'b11:   return {DATA_W{c[3] ^ r[3]}};
      default: return '0;
    endcase
  endfunction

  always_comb begin
    state_nx = state;
    cfg_nx   = cfg;
    tmr_nx   = tmr;
    phase_nx = phase;
    col_nx   = col;
    row_nx   = row;
    field_nx = field;
    frame_nx = frame;
    done_nx  = 1'b0;
    case (state)
      S_IDLE: if (start) begin
        state_nx = S_H_PRE;
        cfg_nx   = '{nframes: nframes, mode: mode};
        tmr_nx   = '0;
        phase_nx = '0;
        col_nx   = '0;
        row_nx   = '0;
        field_nx = '0;
        frame_nx = '0;
      end
      S_H_PRE: if (tmr == T_PRE_END) begin
        state_nx = S_H_ACT;
        tmr_nx   = '0;
        phase_nx = '0;
        col_nx   = '0;
      end else tmr_nx = tmr + 1'b1;
      S_H_ACT: begin
        tmr_nx   = tmr + 1'b1;
        phase_nx = (phase == PH_LAST) ? '0 : phase + 1'b1;
        if (phase == PH_LAST) col_nx = col + 1'b1;
        if (tmr == T_ACT_END) begin
          state_nx = S_H_POST;
          tmr_nx   = '0;
          col_nx   = '0;
        end
      end
      S_H_POST: if (tmr == T_POST_END) begin
        tmr_nx = '0;
        if (row == ROW_LAST) begin
          row_nx   = '0;
          state_nx = S_V_GAP;
        end else begin
          row_nx   = row + 1'b1;
          state_nx = S_H_PRE;
        end
      end else tmr_nx = tmr + 1'b1;
      S_V_GAP: if (tmr == T_GAP_END) begin
        tmr_nx   = '0;
        state_nx = S_H_PRE;
        // stop and the frame budget only take effect on a whole-frame boundary
        if (field == FLD_LAST) begin
          field_nx = '0;
          frame_nx = frame + 1'b1;
          if ((cfg.nframes != '0 && frame_nx == cfg.nframes) || stop_pend) begin
            state_nx = S_IDLE;
            done_nx  = 1'b1;
          end
        end else field_nx = field + 1'b1;
      end else tmr_nx = tmr + 1'b1;
      default: state_nx = S_IDLE;
    endcase
  end

  assign fbit_nx  = (FIELDS > 1) ? field_nx[0] : 1'b0;
  assign pix_edge = (state_nx == S_H_ACT);

  // Outputs are registered from next-state values so they line up with the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cfg       <= '0;
      tmr       <= '0;
      phase     <= '0;
      col       <= '0;
      row       <= '0;
      field     <= '0;
      frame     <= '0;
      stop_pend <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      vid.pix_req           <= 1'b0;
      vid.video_frame_valid <= 1'b0;
      vid.video_line_valid  <= 1'b0;
      vid.video_data_valid  <= 1'b0;
      vid.video_data_out    <= '0;
      vid.video_address     <= '0;
    end else begin
      state <= state_nx;
      cfg   <= cfg_nx;
      tmr   <= tmr_nx;
      phase <= phase_nx;
      col   <= col_nx;
      row   <= row_nx;
      field <= field_nx;
      frame <= frame_nx;
      if (state_nx == S_IDLE)             stop_pend <= 1'b0;
      else if (stop && state != S_IDLE)   stop_pend <= 1'b1;
      busy <= (state_nx != S_IDLE);
      done <= done_nx;
      vid.video_frame_valid <= (state_nx == S_H_PRE) || (state_nx == S_H_ACT) ||
                               (state_nx == S_H_POST);
      vid.video_line_valid  <= pix_edge;
      vid.video_data_valid  <= pix_edge && (phase_nx == PH_VALID);
      vid.pix_req           <= pix_edge && (phase_nx == '0) && (cfg_nx.mode == 2'b00);
      if (pix_edge && phase_nx == '0)
        vid.video_address <= {row_nx, fbit_nx, col_nx};
      if (pix_edge && phase_nx == PH_ONE && cfg_nx.mode != 2'b00)
        vid.video_data_out <= pattern(cfg_nx.mode, col_nx, row_nx);
      // external pixel arrives the clock after pix_req, i.e. during phase 1
      if (state == S_H_ACT && phase == PH_ONE && cfg.mode == 2'b00)
        vid.video_data_out <= vid.pix_in;
    end
  end

endmodule

// File: tb/tb_video_stream_gen.sv
// Directed bench for video_stream_gen on a shrunken raster (20 px x 10 lines x 2 fields).
module tb_video_stream_gen;
  localparam int H_ACTIVE = 20, V_LINES = 10, PIX_DIV = 4, PIX_PHASE = 2;
  localparam int H_PRE = 5, H_POST = 7, V_GAP = 20;
  localparam int LIM = 10000;

  logic       clk, rst_n, start, stop, busy, done, clr;
  logic [7:0] nframes, pix_val;
  logic [1:0] mode;
  logic [19:0] tgt_addr;
  int n_vec = 0, n_err = 0;
  int dv_cnt, req_cnt, done_cnt, cap_hit;
  logic [7:0] cap_data;

  video_stream_gen_if #(.DATA_W(8), .ROW_W(9), .COL_W(10)) vif();

  video_stream_gen #(
    .H_ACTIVE(H_ACTIVE), .V_LINES(V_LINES), .FIELDS(2), .DATA_W(8),
    .PIX_DIV(PIX_DIV), .PIX_PHASE(PIX_PHASE), .H_PRE(H_PRE), .H_POST(H_POST),
    .V_GAP(V_GAP), .ROW_W(9), .COL_W(10), .NF_W(8)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .nframes(nframes),
    .mode(mode), .vid(vif), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // external pixel source: answers pix_req for exactly one clock
  always @(posedge clk) vif.pix_in <= vif.pix_req ? pix_val : 8'h00;

  always @(negedge clk) begin
    if (clr) begin
      dv_cnt = 0; req_cnt = 0; done_cnt = 0; cap_hit = 0; cap_data = 8'h00;
    end else begin
      if (vif.video_data_valid) begin
        dv_cnt++;
        if (vif.video_address == tgt_addr) begin
          cap_hit++;
          cap_data = vif.video_data_out;
        end
      end
      if (vif.pix_req) req_cnt++;
      if (done) done_cnt++;
    end
  end

  typedef struct {
    logic [1:0] mode;
    logic [7:0] nf;
    logic [7:0] pix;
    int         f, r, c;
    logic [7:0] exp_data;
    int         exp_dv, exp_req;
  } vec_t;
  vec_t tbl[10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic sig(input int which);
    case (which)
      0: return vif.video_frame_valid;
      1: return vif.video_line_valid;
      2: return vif.video_data_valid;
      default: return done;
    endcase
  endfunction

  function automatic logic [31:0] outs();
    return {24'd0, vif.video_frame_valid, vif.video_line_valid, vif.video_data_valid,
            vif.pix_req, busy, done, |vif.video_address, |vif.video_data_out};
  endfunction

  task automatic wait_sig(input int which, input logic lvl, input string nm);
    int n = 0;
    while (sig(which) !== lvl && n < LIM) begin
      @(negedge clk); n++;
    end
    if (n >= LIM) begin
      n_vec++; n_err++;
      $display("FAIL %s: timeout after %0d cycles, expected level %0b", nm, n, lvl);
    end
  endtask

  task automatic clear();
    @(posedge clk); clr = 1'b1;
    @(posedge clk); clr = 1'b0;
  endtask

  task automatic kick(input logic [1:0] m, input logic [7:0] nf);
    clear();
    @(negedge clk); mode = m; nframes = nf; start = 1'b1;
    // change the live inputs so only the latched copies can be correct
    @(negedge clk); start = 1'b0; mode = ~m; nframes = 8'd0;
  endtask

  initial begin
    int n, k, first, last, cnt, bad;
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; mode = 2'b00; nframes = 8'd0;
    pix_val = 8'h00; clr = 1'b0; tgt_addr = '1;

    tbl[0] = '{2'd1, 8'd1, 8'h00, 0, 0, 13, 8'h0D, 400, 0};
    tbl[1] = '{2'd1, 8'd1, 8'h00, 1, 9, 19, 8'h13, 400, 0};
    tbl[2] = '{2'd2, 8'd1, 8'h00, 0, 7, 5,  8'h07, 400, 0};
    tbl[3] = '{2'd2, 8'd1, 8'h00, 1, 9, 0,  8'h09, 400, 0};
    tbl[4] = '{2'd3, 8'd1, 8'h00, 0, 3, 12, 8'hFF, 400, 0};
    tbl[5] = '{2'd3, 8'd1, 8'h00, 1, 8, 4,  8'hFF, 400, 0};
    tbl[6] = '{2'd3, 8'd1, 8'h00, 0, 9, 2,  8'hFF, 400, 0};
    tbl[7] = '{2'd0, 8'd1, 8'hA5, 0, 1, 7,  8'hA5, 400, 400};
    tbl[8] = '{2'd0, 8'd1, 8'h3C, 1, 9, 19, 8'h3C, 400, 400};
    tbl[9] = '{2'd1, 8'd2, 8'h00, 1, 0, 8,  8'h08, 800, 0};

    repeat (2) @(negedge clk);
    chk("reset_outputs", outs(), 32'd0);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("idle_after_release", outs(), 32'd0);

    // line and field timing
    kick(2'd1, 8'd1);
    chk("busy_next_cycle", {31'd0, busy}, 32'd1);
    chk("fv_at_start", {31'd0, vif.video_frame_valid}, 32'd1);
    n = 0;
    while (!vif.video_line_valid && n < LIM) begin @(negedge clk); n++; end
    chk("h_pre_len", n, H_PRE);
    n = 0; first = -1; last = 0; cnt = 0; bad = 0;
    while (vif.video_line_valid && n < LIM) begin
      if (vif.video_data_valid) begin
        if (first < 0) first = n;
        else if (n - last != PIX_DIV) bad++;
        last = n; cnt++;
      end
      @(negedge clk); n++;
    end
    chk("h_act_len", n, H_ACTIVE * PIX_DIV);
    chk("dv_phase", first, PIX_PHASE);
    chk("dv_per_line", cnt, H_ACTIVE);
    chk("dv_spacing_err", bad, 0);
    n = 0;
    while (!vif.video_line_valid && n < LIM) begin @(negedge clk); n++; end
    chk("line_gap", n, H_POST + H_PRE);
    n = 0; k = 0;
    while (vif.video_frame_valid && n < LIM) begin
      @(negedge clk); n++;
      k = vif.video_line_valid ? 0 : k + 1;
    end
    chk("post_to_fv_fall", k, H_POST + 1);
    n = 0;
    while (!vif.video_frame_valid && n < LIM) begin @(negedge clk); n++; end
    chk("v_gap_len", n, V_GAP);
    wait_sig(2, 1'b1, "dv_field1");
    chk("field1_addr", vif.video_address, {9'd0, 1'b1, 10'd0});
    wait_sig(3, 1'b1, "done_timing");
    repeat (3) @(negedge clk);

    // graceful stop mid-field 0 in endless mode, stray start ignored
    tgt_addr = '1;
    kick(2'd1, 8'd0);
    repeat (100) @(negedge clk);
    stop = 1'b1;
    @(negedge clk); stop = 1'b0;
    repeat (50) @(negedge clk);
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    wait_sig(3, 1'b1, "done_stop");
    repeat (60) @(negedge clk);
    chk("stop_dv_cnt", dv_cnt, 400);
    chk("stop_done_cnt", done_cnt, 1);
    chk("stop_busy_after", {31'd0, busy}, 32'd0);

    for (int i = 0; i < 10; i++) begin
      pix_val  = tbl[i].pix;
      tgt_addr = {9'(tbl[i].r), 1'(tbl[i].f), 10'(tbl[i].c)};
      kick(tbl[i].mode, tbl[i].nf);
      wait_sig(3, 1'b1, $sformatf("v%0d_done", i));
      repeat (3) @(negedge clk);
      chk($sformatf("v%0d_data", i), cap_data, tbl[i].exp_data);
      chk($sformatf("v%0d_addr_hits", i), cap_hit, tbl[i].nf);
      chk($sformatf("v%0d_dv_cnt", i), dv_cnt, tbl[i].exp_dv);
      chk($sformatf("v%0d_req_cnt", i), req_cnt, tbl[i].exp_req);
      chk($sformatf("v%0d_done_cnt", i), done_cnt, 1);
      chk($sformatf("v%0d_busy_after", i), {31'd0, busy}, 32'd0);
    end

    // asynchronous reset in the middle of an active line
    tgt_addr = '1;
    kick(2'd1, 8'd1);
    wait_sig(1, 1'b1, "lv_before_reset");
    repeat (10) @(negedge clk);
    chk("active_before_reset", {30'd0, vif.video_frame_valid, vif.video_line_valid}, 32'd3);
    rst_n = 1'b0;
    #1;
    chk("reset_mid_line", outs(), 32'd0);
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    chk("idle_after_mid_reset", outs(), 32'd0);
    kick(2'd1, 8'd1);
    wait_sig(2, 1'b1, "dv_after_restart");
    chk("restart_addr0", vif.video_address, 20'd0);
    @(negedge clk);
    wait_sig(2, 1'b1, "dv2_after_restart");
    chk("restart_addr1", vif.video_address, {9'd0, 1'b0, 10'd1});
    chk("restart_data1", vif.video_data_out, 8'd1);
    wait_sig(3, 1'b1, "done_restart");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
